// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - sequential instruction fetch with outstanding-request credit and in-order instruction queue
//
// Purpose: issues sequential fetch PCs on an inst_sram-style split request/response
// bus, keeps up to OUTST requests in flight, buffers returned instructions in an
// IBUF_DEPTH-entry in-order queue for the predecode stage, flushes on redirect and
// tags misaligned PCs with ADEF.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   redirect_valid/_pc         flush and restart fetch at redirect_pc
//   pD_allowin                 downstream ready
//   FpD_valid/_pc/_inst        queue head entry
//   FpD_ex/_ecode              head entry carries ADEF
//   inst_sram_req/_addr        fetch request
//   inst_sram_addr_ok          request accepted
//   inst_sram_data_ok/_rdata   in-order response

`ifndef ECODE_ADEF
`define ECODE_ADEF 8'h08
`endif

module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter int          OUTST      = 2,
   parameter int          IBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        pD_allowin,
   output logic        FpD_valid,
   output logic [31:0] FpD_pc,
   output logic [31:0] FpD_inst,
   output logic        FpD_ex,
   output logic [7:0]  FpD_ecode,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   localparam int IW  = $clog2(OUTST + 1);
   localparam int CW  = $clog2(IBUF_DEPTH + 1);
   localparam int PPW = (OUTST > 1) ? $clog2(OUTST) : 1;
   localparam int QPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

   // fetch control state
   logic [31:0]    r_pc;
   logic           r_halt;
   logic [IW-1:0]  r_inflight;
   logic [IW-1:0]  r_discard;

   // pending-PC FIFO: one entry per accepted request, popped by each response
   logic [31:0]    r_pp_pc [OUTST];
   logic [PPW-1:0] r_pp_wr;
   logic [PPW-1:0] r_pp_rd;

   // instruction queue
   logic [31:0]    r_q_pc   [IBUF_DEPTH];
   logic [31:0]    r_q_inst [IBUF_DEPTH];
   logic           r_q_ex   [IBUF_DEPTH];
   logic [QPW-1:0] r_head;
   logic [QPW-1:0] r_tail;
   logic [CW-1:0]  r_count;

   logic           w_misaligned;
   logic           w_credit;
   logic           w_req;
   logic           w_accept;
   logic           w_resp;
   logic           w_keep;
   logic           w_adef;
   logic           w_push;
   logic           w_pop;
   logic           w_valid;
   logic [31:0]    w_push_pc;
   logic [31:0]    w_push_inst;
   logic [PPW-1:0] w_pp_wr_nxt;
   logic [PPW-1:0] w_pp_rd_nxt;
   logic [QPW-1:0] w_head_nxt;
   logic [QPW-1:0] w_tail_nxt;

   assign w_misaligned = (r_pc[1:0] != 2'b00);

   // Credit counts only registered occupancy; a same-cycle pop never frees a slot,
   // so inflight + count can never exceed the queue size.
   assign w_credit = (32'(r_inflight) < 32'(OUTST)) &&
                     ((32'(r_inflight) + 32'(r_count)) < 32'(IBUF_DEPTH));

   assign w_req    = rstn & ~r_halt & ~redirect_valid & ~w_misaligned & w_credit;
   assign w_accept = w_req & inst_sram_addr_ok;

   // A response with nothing in flight is a bus protocol error and is ignored.
   assign w_resp   = inst_sram_data_ok & (r_inflight != '0);
   assign w_keep   = w_resp & (r_discard == '0) & ~redirect_valid;

   // ADEF entry waits until the bus is fully drained so it lands behind every
   // older instruction in program order.
   assign w_adef   = ~r_halt & ~redirect_valid & w_misaligned &
                     (r_inflight == '0) & (r_discard == '0) &
                     (32'(r_count) < 32'(IBUF_DEPTH));

   // w_keep and w_adef are exclusive: w_adef needs nothing in flight.
   assign w_push      = w_keep | w_adef;
   assign w_valid     = (r_count != '0);
   assign w_pop       = w_valid & pD_allowin & ~redirect_valid;
   assign w_push_pc   = w_adef ? r_pc  : r_pp_pc[r_pp_rd];
   assign w_push_inst = w_adef ? 32'h0 : inst_sram_rdata;

   assign w_pp_wr_nxt = (r_pp_wr == PPW'(OUTST - 1))      ? '0 : r_pp_wr + PPW'(1);
   assign w_pp_rd_nxt = (r_pp_rd == PPW'(OUTST - 1))      ? '0 : r_pp_rd + PPW'(1);
   assign w_head_nxt  = (r_head  == QPW'(IBUF_DEPTH - 1)) ? '0 : r_head  + QPW'(1);
   assign w_tail_nxt  = (r_tail  == QPW'(IBUF_DEPTH - 1)) ? '0 : r_tail  + QPW'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pc       <= RESET_PC;
         r_halt     <= 1'b0;
         r_inflight <= '0;
         r_discard  <= '0;
         r_pp_wr    <= '0;
         r_pp_rd    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         // The pending FIFO and inflight follow the bus regardless of flushes;
         // stale responses still pop their PC, they are just not queued.
         if (w_accept) r_pp_wr <= w_pp_wr_nxt;
         if (w_resp)   r_pp_rd <= w_pp_rd_nxt;
         case ({w_accept, w_resp})
            2'b10:   r_inflight <= r_inflight + IW'(1);
            2'b01:   r_inflight <= r_inflight - IW'(1);
            default: r_inflight <= r_inflight;
         endcase

         if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_halt  <= 1'b0;
            // Every in-flight response becomes stale. Responses already marked for
            // discard are a subset of inflight, so inflight alone is the new total;
            // a response arriving this cycle consumes one of them.
            r_discard <= r_inflight - IW'(w_resp);
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            if (w_adef)   r_halt <= 1'b1;
            if (w_resp && (r_discard != '0)) r_discard <= r_discard - IW'(1);
            if (w_push)   r_tail <= w_tail_nxt;
            if (w_pop)    r_head <= w_head_nxt;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Storage needs no reset: every read of it is qualified by occupancy.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pp_pc[r_pp_wr] <= r_pc;
      end
      if (w_push && !redirect_valid) begin
         r_q_pc[r_tail]   <= w_push_pc;
         r_q_inst[r_tail] <= w_push_inst;
         r_q_ex[r_tail]   <= w_adef;
      end
   end

   // Bus outputs are gated by rstn so they read 0 for the whole reset window.
   assign inst_sram_req  = w_req;
   assign inst_sram_addr = rstn ? r_pc : 32'h0;

   assign FpD_valid = w_valid;
   assign FpD_pc    = w_valid ? r_q_pc[r_head] : 32'h0;
   assign FpD_ex    = w_valid & r_q_ex[r_head];
   assign FpD_inst  = (w_valid && !r_q_ex[r_head]) ? r_q_inst[r_head] : 32'h0;
   assign FpD_ecode = FpD_ex ? `ECODE_ADEF : 8'h00;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

   logic        clk;
   logic        rstn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        pD_allowin;
   logic        FpD_valid;
   logic [31:0] FpD_pc;
   logic [31:0] FpD_inst;
   logic        FpD_ex;
   logic [7:0]  FpD_ecode;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic        resp_en;
   logic [31:0] bq[$];
   int          bq_n;
   logic [31:0] bq_hd;

   int n_cmp;
   int n_err;

   fetch_queue_unit #(
      .RESET_PC   (32'h1c000000),
      .OUTST      (2),
      .IBUF_DEPTH (4)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .pD_allowin        (pD_allowin),
      .FpD_valid         (FpD_valid),
      .FpD_pc            (FpD_pc),
      .FpD_inst          (FpD_inst),
      .FpD_ex            (FpD_ex),
      .FpD_ecode         (FpD_ecode),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // In-order memory: answers each accepted request one cycle later (while
   // resp_en is set) with data = ~address.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bq.delete();
         bq_n  <= 0;
         bq_hd <= 32'h0;
      end else begin
         if (inst_sram_data_ok) void'(bq.pop_front());
         if (inst_sram_req && inst_sram_addr_ok) bq.push_back(inst_sram_addr);
         bq_n  <= bq.size();
         bq_hd <= (bq.size() > 0) ? ~bq[0] : 32'h0;
      end
   end

   assign inst_sram_data_ok = resp_en && (bq_n > 0);
   assign inst_sram_rdata   = bq_hd;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      rstn           = 1'b0;
      redirect_valid = 1'b0;
      resp_en        = 1'b0;
      tick;
      tick;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      pD_allowin = 1'b0; inst_sram_addr_ok = 1'b0; resp_en = 1'b0;
      #3;
      chk("rst_valid", {31'h0, FpD_valid}, 32'h0);
      chk("rst_req", {31'h0, inst_sram_req}, 32'h0);
      chk("rst_addr", inst_sram_addr, 32'h0);
      chk("rst_pc", FpD_pc, 32'h0);
      chk("rst_ecode", {24'h0, FpD_ecode}, 32'h0);
      tick;
      tick;

      // streaming
      inst_sram_addr_ok = 1'b1; resp_en = 1'b1; pD_allowin = 1'b1;
      rstn = 1'b1;
      #1;
      chk("st_first_req", {31'h0, inst_sram_req}, 32'h1);
      chk("st_first_addr", inst_sram_addr, 32'h1c000000);
      tick;
      chk("st_not_yet", {31'h0, FpD_valid}, 32'h0);
      tick;
      for (int i = 0; i < 8; i++) begin
         chk("st_valid", {31'h0, FpD_valid}, 32'h1);
         chk("st_pc", FpD_pc, 32'h1c000000 + 32'(4 * i));
         chk("st_inst", FpD_inst, ~(32'h1c000000 + 32'(4 * i)));
         chk("st_inflight_le2", (bq_n <= 2) ? 32'h1 : 32'h0, 32'h1);
         tick;
      end

      // asynchronous reset between edges
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", {31'h0, FpD_valid}, 32'h0);
      chk("arst_req", {31'h0, inst_sram_req}, 32'h0);
      chk("arst_addr", inst_sram_addr, 32'h0);
      chk("arst_pc", FpD_pc, 32'h0);
      chk("arst_inst", FpD_inst, 32'h0);
      tick;
      tick;

      // backpressure
      pD_allowin = 1'b0;
      rstn = 1'b1;
      #1;
      chk("arst_rel_req", {31'h0, inst_sram_req}, 32'h1);
      chk("arst_rel_addr", inst_sram_addr, 32'h1c000000);
      tick; tick; tick; tick;
      chk("bp_req_off", {31'h0, inst_sram_req}, 32'h0);
      tick;
      chk("bp_valid", {31'h0, FpD_valid}, 32'h1);
      chk("bp_head", FpD_pc, 32'h1c000000);
      chk("bp_drained", 32'(bq_n), 32'h0);
      chk("bp_req_held", {31'h0, inst_sram_req}, 32'h0);
      tick;
      chk("bp_req_still", {31'h0, inst_sram_req}, 32'h0);
      chk("bp_next_addr", inst_sram_addr, 32'h1c000010);
      pD_allowin = 1'b1;
      tick;
      chk("bp_rel_pc", FpD_pc, 32'h1c000004);
      chk("bp_rel_req", {31'h0, inst_sram_req}, 32'h1);
      chk("bp_rel_addr", inst_sram_addr, 32'h1c000010);
      for (int i = 1; i < 6; i++) begin
         tick;
         chk("bp_seq_valid", {31'h0, FpD_valid}, 32'h1);
         chk("bp_seq_pc", FpD_pc, 32'h1c000004 + 32'(4 * i));
         chk("bp_seq_inst", FpD_inst, ~(32'h1c000004 + 32'(4 * i)));
      end

      // flush with two requests in flight
      do_reset;
      inst_sram_addr_ok = 1'b1; pD_allowin = 1'b1;
      rstn = 1'b1;
      tick;
      tick;
      chk("fl_req_full", {31'h0, inst_sram_req}, 32'h0);
      chk("fl_inflight", 32'(bq_n), 32'h2);
      redirect_valid = 1'b1; redirect_pc = 32'h1c000100;
      #1;
      chk("fl_req_forced", {31'h0, inst_sram_req}, 32'h0);
      tick;
      redirect_valid = 1'b0; resp_en = 1'b1;
      #1;
      chk("fl_valid0", {31'h0, FpD_valid}, 32'h0);
      tick;
      chk("fl_valid1", {31'h0, FpD_valid}, 32'h0);
      chk("fl_req_resume", {31'h0, inst_sram_req}, 32'h1);
      chk("fl_addr_resume", inst_sram_addr, 32'h1c000100);
      tick;
      chk("fl_valid2", {31'h0, FpD_valid}, 32'h0);
      tick;
      chk("fl_new_valid", {31'h0, FpD_valid}, 32'h1);
      chk("fl_new_pc", FpD_pc, 32'h1c000100);
      chk("fl_new_inst", FpD_inst, ~32'h1c000100);
      tick;
      chk("fl_next_pc", FpD_pc, 32'h1c000104);

      // redirect coinciding with a response
      do_reset;
      inst_sram_addr_ok = 1'b1; pD_allowin = 1'b1;
      rstn = 1'b1;
      tick;
      tick;
      resp_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1c000180;
      tick;
      redirect_valid = 1'b0;
      #1;
      chk("rc_valid0", {31'h0, FpD_valid}, 32'h0);
      chk("rc_req", {31'h0, inst_sram_req}, 32'h1);
      chk("rc_addr", inst_sram_addr, 32'h1c000180);
      tick;
      chk("rc_valid1", {31'h0, FpD_valid}, 32'h0);
      tick;
      chk("rc_new_valid", {31'h0, FpD_valid}, 32'h1);
      chk("rc_new_pc", FpD_pc, 32'h1c000180);
      chk("rc_new_inst", FpD_inst, ~32'h1c000180);
      tick;
      chk("rc_next_pc", FpD_pc, 32'h1c000184);

      // misaligned redirect
      pD_allowin = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1c000102;
      #1;
      chk("ad_req_redir", {31'h0, inst_sram_req}, 32'h0);
      tick;
      redirect_valid = 1'b0;
      #1;
      chk("ad_valid0", {31'h0, FpD_valid}, 32'h0);
      chk("ad_req0", {31'h0, inst_sram_req}, 32'h0);
      tick;
      chk("ad_valid", {31'h0, FpD_valid}, 32'h1);
      chk("ad_ex", {31'h0, FpD_ex}, 32'h1);
      chk("ad_ecode", {24'h0, FpD_ecode}, 32'h08);
      chk("ad_pc", FpD_pc, 32'h1c000102);
      chk("ad_inst", FpD_inst, 32'h0);
      chk("ad_req1", {31'h0, inst_sram_req}, 32'h0);
      pD_allowin = 1'b1;
      tick;
      chk("ad_popped", {31'h0, FpD_valid}, 32'h0);
      chk("ad_req2", {31'h0, inst_sram_req}, 32'h0);
      tick;
      tick;
      chk("ad_halt_valid", {31'h0, FpD_valid}, 32'h0);
      chk("ad_halt_req", {31'h0, inst_sram_req}, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h1c000200;
      tick;
      redirect_valid = 1'b0;
      #1;
      chk("ad_resume_req", {31'h0, inst_sram_req}, 32'h1);
      chk("ad_resume_addr", inst_sram_addr, 32'h1c000200);
      tick;
      tick;
      chk("ad_resume_valid", {31'h0, FpD_valid}, 32'h1);
      chk("ad_resume_pc", FpD_pc, 32'h1c000200);
      chk("ad_resume_ex", {31'h0, FpD_ex}, 32'h0);
      chk("ad_resume_inst", FpD_inst, ~32'h1c000200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
